// File: rtl/bar_sprite_pkg.sv
// bar_sprite_pkg: shared register map, ctrl layout and ctrl packing helper for bar_sprite_ctrl
package bar_sprite_pkg;
  localparam int RAM_SEL_BIT = 13;
  localparam logic [1:0] REG_X0 = 2'd0;
  localparam logic [1:0] REG_Y0 = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_WRAP = 2'd3;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_SPEED_LSB = 4;
  typedef struct packed {
    logic [3:0] speed;
    logic auto;
    logic en;
  } ctrl_t;
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT] = c.en;
    w[CTRL_AUTO_BIT] = c.auto;
    w[CTRL_SPEED_LSB +: 4] = c.speed;
    return w;
  endfunction
endpackage

// File: rtl/bar_ram.sv
// bar_ram: sprite bitmap store; ports clk, write port (we, addr_w, din), registered read port (addr_r -> dout one clock later)
module bar_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= din;
    dout <= mem[addr_r];
  end
endmodule

// File: rtl/bar_sprite_ctrl.sv
// bar_sprite_ctrl: bar sprite overlay; bus slot (cs, write, addr, wr_data, rd_data), scan position (x, y, frame_tick), pixel stream si_rgb -> so_rgb, clk/reset_n
module bar_sprite_ctrl
  import bar_sprite_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 10,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int Y_LIMIT = 480,
  parameter int CHROMA_KEY = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  write,
  input  logic [13:0]           addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic [DATA_WIDTH-1:0] si_rgb,
  output logic [DATA_WIDTH-1:0] so_rgb
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  logic [10:0] x0, y0, pend_x0, pend_y0;
  ctrl_t ctrl, pend_ctrl, wr_ctrl, tick_ctrl;
  logic dirty_x, dirty_y, dirty_c;
  logic [15:0] wrap_count;
  logic ram_we, reg_wr, wr_x, wr_y, wr_c, scroll, wrap;
  logic [11:0] y_sum, dx, dy;
  logic hit, hit_d;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] pix, rgb_d;
  logic unused_bits;
  assign unused_bits = ^{addr, wr_data};
  always_comb begin
    ram_we = cs & write & addr[RAM_SEL_BIT];
    reg_wr = cs & write & ~addr[RAM_SEL_BIT];
    wr_x = reg_wr & (addr[1:0] == REG_X0);
    wr_y = reg_wr & (addr[1:0] == REG_Y0);
    wr_c = reg_wr & (addr[1:0] == REG_CTRL);
    wr_ctrl = '{speed: wr_data[CTRL_SPEED_LSB +: 4], auto: wr_data[CTRL_AUTO_BIT], en: wr_data[CTRL_EN_BIT]};
    tick_ctrl = dirty_c ? pend_ctrl : ctrl;
    y_sum = {1'b0, y0} + {8'b0, tick_ctrl.speed};
    wrap = y_sum >= 12'(Y_LIMIT);
    // a y0 write landing on the tick counts as dirty, so it suppresses that tick's scroll
    scroll = tick_ctrl.auto & ~dirty_y & ~wr_y;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_x0 <= '0;
      pend_y0 <= '0;
      pend_ctrl <= '0;
      dirty_x <= 1'b0;
      dirty_y <= 1'b0;
      dirty_c <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      ctrl <= '0;
      wrap_count <= '0;
    end else begin
      if (wr_x) pend_x0 <= wr_data[10:0];
      if (wr_y) pend_y0 <= wr_data[10:0];
      if (wr_c) pend_ctrl <= wr_ctrl;
      dirty_x <= wr_x | (dirty_x & ~frame_tick);
      dirty_y <= wr_y | (dirty_y & ~frame_tick);
      dirty_c <= wr_c | (dirty_c & ~frame_tick);
      if (frame_tick) begin
        ctrl <= tick_ctrl;
        if (dirty_x) x0 <= pend_x0;
        if (dirty_y) y0 <= pend_y0;
        else if (scroll) y0 <= wrap ? '0 : y_sum[10:0];
        if (scroll & wrap) wrap_count <= wrap_count + 16'd1;
      end
    end
  end
  always_comb
    rd_data = addr[RAM_SEL_BIT] ? '0 :
              addr[1:0] == REG_X0 ? {21'b0, x0} :
              addr[1:0] == REG_Y0 ? {21'b0, y0} :
              addr[1:0] == REG_CTRL ? ctrl_word(ctrl) : {16'b0, wrap_count};
  always_comb begin
    dx = {1'b0, x} - {1'b0, x0};
    dy = {1'b0, y} - {1'b0, y0};
    hit = ~dx[11] & ~dy[11] & (dx < 12'(SPR_W)) & (dy < 12'(SPR_H));
    addr_r = {dy[YW-1:0], dx[XW-1:0]};
  end
  bar_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr_w(addr[ADDR_WIDTH-1:0]),
    .din(wr_data[DATA_WIDTH-1:0]),
    .addr_r(addr_r),
    .dout(pix)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d <= 1'b0;
      rgb_d <= '0;
      so_rgb <= '0;
    end else begin
      hit_d <= hit;
      rgb_d <= si_rgb;
      so_rgb <= (hit_d & ctrl.en & (pix != DATA_WIDTH'(CHROMA_KEY))) ? pix : rgb_d;
    end
  end
endmodule
